// File: rtl/switch_selection_decoder_if.sv
// Code-word stream from the selection FSM plus the decoder's status outputs.
// The master drives codes in; the slave decodes them and reports lock and error status.
interface switch_selection_decoder_if;
    logic [15:0] code_in;
    logic        code_valid;
    logic [31:0] sel_out;
    logic        sel_valid;
    logic        locked;
    logic        error_flag;
    logic [15:0] match_count;
    logic [15:0] error_count;

    modport master (
        output code_in, code_valid,
        input  sel_out, sel_valid, locked, error_flag, match_count, error_count
    );

    modport slave (
        input  code_in, code_valid,
        output sel_out, sel_valid, locked, error_flag, match_count, error_count
    );
endinterface

// File: rtl/switch_selection_decoder.sv
// Decodes the two-way selection code stream back to a selector value, checks that
// selections strictly alternate, tracks lock and keeps saturating match/error counts.
module switch_selection_decoder #(
    parameter logic [15:0] CODE0      = 16'h0123,
    parameter logic [15:0] CODE1      = 16'h0ABC,
    parameter int          LOCK_COUNT = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    switch_selection_decoder_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_TARGET = 8'(LOCK_COUNT);

    state_t      state_q, state_d;
    logic [7:0]  run_q, run_d;
    logic        expected_q, expected_d;
    logic [31:0] sel_out_q, sel_out_d;
    logic        sel_valid_q, sel_valid_d;
    logic        locked_q, locked_d;
    logic        error_flag_q, error_flag_d;
    logic [15:0] match_count_q, match_count_d;
    logic [15:0] error_count_q, error_count_d;

    logic        code_known;
    logic        code_sel;
    logic [7:0]  run_plus;

    assign code_known = (bus.code_in == CODE0) || (bus.code_in == CODE1);
    assign code_sel   = (bus.code_in == CODE1);
    // run only grows while in TRACK, which is left once it reaches LOCK_TARGET (<= 255)
    assign run_plus   = run_q + 8'd1;

    always_comb begin
        state_d       = state_q;
        run_d         = run_q;
        expected_d    = expected_q;
        sel_out_d     = sel_out_q;
        sel_valid_d   = 1'b0;
        locked_d      = locked_q;
        error_flag_d  = 1'b0;
        match_count_d = match_count_q;
        error_count_d = error_count_q;

        if (bus.code_valid) begin
            if (code_known) begin
                sel_out_d   = {31'd0, code_sel};
                sel_valid_d = 1'b1;
            end

            if (!code_known) begin
                error_flag_d = 1'b1;
                if (error_count_q != 16'hFFFF) begin
                    error_count_d = error_count_q + 16'd1;
                end
                locked_d = 1'b0;
                run_d    = 8'd0;
                state_d  = ST_INIT;
            end else if (state_q == ST_INIT) begin
                expected_d = !code_sel;
                run_d      = 8'd1;
                if (LOCK_COUNT == 1) begin
                    locked_d = 1'b1;
                    state_d  = ST_LOCKED;
                end else begin
                    state_d  = ST_TRACK;
                end
            end else if (code_sel == expected_q) begin
                expected_d = !expected_q;
                if (match_count_q != 16'hFFFF) begin
                    match_count_d = match_count_q + 16'd1;
                end
                if (state_q == ST_TRACK) begin
                    run_d = run_plus;
                    // >= so a LOCK_COUNT of 1 still locks after a repeat-restart
                    if (run_plus >= LOCK_TARGET) begin
                        locked_d = 1'b1;
                        state_d  = ST_LOCKED;
                    end
                end
            end else begin
                // Repeated selection: this code restarts the run as a new first code
                error_flag_d = 1'b1;
                if (error_count_q != 16'hFFFF) begin
                    error_count_d = error_count_q + 16'd1;
                end
                locked_d   = 1'b0;
                expected_d = !code_sel;
                run_d      = 8'd1;
                state_d    = ST_TRACK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_INIT;
            run_q         <= 8'd0;
            expected_q    <= 1'b0;
            sel_out_q     <= 32'd0;
            sel_valid_q   <= 1'b0;
            locked_q      <= 1'b0;
            error_flag_q  <= 1'b0;
            match_count_q <= 16'd0;
            error_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            expected_q    <= expected_d;
            sel_out_q     <= sel_out_d;
            sel_valid_q   <= sel_valid_d;
            locked_q      <= locked_d;
            error_flag_q  <= error_flag_d;
            match_count_q <= match_count_d;
            error_count_q <= error_count_d;
        end
    end

    assign bus.sel_out     = sel_out_q;
    assign bus.sel_valid   = sel_valid_q;
    assign bus.locked      = locked_q;
    assign bus.error_flag  = error_flag_q;
    assign bus.match_count = match_count_q;
    assign bus.error_count = error_count_q;

endmodule

// File: tb/tb_switch_selection_decoder.sv
// Directed scoreboard bench for switch_selection_decoder: the driver queues the
// expected response of every code, and a monitor pops it on each sel_valid/error_flag pulse.
module tb_switch_selection_decoder;

    logic clk;
    logic reset;

    switch_selection_decoder_if bus ();

    switch_selection_decoder #(
        .CODE0      (16'h0123),
        .CODE1      (16'h0ABC),
        .LOCK_COUNT (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          id;
        logic [15:0] code;
        logic [31:0] sel;
        logic        sv;
        logic        lk;
        logic        ef;
        logic [15:0] mc;
        logic [15:0] ec;
        bit          quiet;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   next_id = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: every consumed code produces sel_valid and/or error_flag
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.sel_valid || bus.error_flag) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: got sv=%b ef=%b sel=%0d, required no output", bus.sel_valid, bus.error_flag, bus.sel_out);
                end else begin
                    e = sb.pop_front();
                    if (bus.sel_out !== e.sel || bus.sel_valid !== e.sv || bus.locked !== e.lk ||
                        bus.error_flag !== e.ef || bus.match_count !== e.mc || bus.error_count !== e.ec) begin
                        bad++;
                        $display("FAIL txn%0d code=%h: got sel=%0d sv=%b lk=%b ef=%b mc=%0d ec=%h, required sel=%0d sv=%b lk=%b ef=%b mc=%0d ec=%h",
                                 e.id, e.code, bus.sel_out, bus.sel_valid, bus.locked, bus.error_flag, bus.match_count, bus.error_count,
                                 e.sel, e.sv, e.lk, e.ef, e.mc, e.ec);
                    end else if (!e.quiet) begin
                        $display("txn %0d code=%h sel=%0d sv=%b lk=%b ef=%b mc=%0d ec=%h ok",
                                 e.id, e.code, bus.sel_out, bus.sel_valid, bus.locked, bus.error_flag, bus.match_count, bus.error_count);
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] code, input logic [31:0] sel, input logic sv,
                        input logic lk, input logic ef, input logic [15:0] mc,
                        input logic [15:0] ec, input bit quiet);
        exp_t e;
        @(negedge clk);
        bus.code_in    = code;
        bus.code_valid = 1'b1;
        e.id = next_id; e.code = code; e.sel = sel; e.sv = sv; e.lk = lk;
        e.ef = ef; e.mc = mc; e.ec = ec; e.quiet = quiet;
        next_id++;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.code_valid = 1'b0;
            bus.code_in    = 16'h0000;
        end
    endtask

    task automatic check_reset_state(input string tag);
        total++;
        if (bus.sel_out !== 32'd0 || bus.sel_valid !== 1'b0 || bus.locked !== 1'b0 ||
            bus.error_flag !== 1'b0 || bus.match_count !== 16'd0 || bus.error_count !== 16'd0) begin
            bad++;
            $display("FAIL %s: got sel=%0d sv=%b lk=%b ef=%b mc=%0d ec=%0d, required all zero",
                     tag, bus.sel_out, bus.sel_valid, bus.locked, bus.error_flag, bus.match_count, bus.error_count);
        end else begin
            $display("%s: outputs at reset values", tag);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.code_in    = 16'h0000;
        bus.code_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("reset_state");

        // Back-to-back alternating stream; lock after the second code
        send(16'd291,  32'd0, 1, 0, 0, 16'd0, 16'd0, 0);
        send(16'd2748, 32'd1, 1, 1, 0, 16'd1, 16'd0, 0);
        send(16'd291,  32'd0, 1, 1, 0, 16'd2, 16'd0, 0);
        send(16'd2748, 32'd1, 1, 1, 0, 16'd3, 16'd0, 0);

        // Repeated 2748 drops lock; following 291 re-locks
        send(16'd291,  32'd0, 1, 1, 0, 16'd4, 16'd0, 0);
        send(16'd2748, 32'd1, 1, 1, 0, 16'd5, 16'd0, 0);
        send(16'd2748, 32'd1, 1, 0, 1, 16'd5, 16'd1, 0);
        send(16'd291,  32'd0, 1, 1, 0, 16'd6, 16'd1, 0);

        // Unknown code while locked -> back to INIT, sel_out held
        send(16'h5555, 32'd0, 0, 0, 1, 16'd6, 16'd2, 0);
        send(16'd291,  32'd0, 1, 0, 0, 16'd6, 16'd2, 0);
        send(16'd2748, 32'd1, 1, 1, 0, 16'd7, 16'd2, 0);

        // Gaps of three idle cycles between codes
        idle(3);
        send(16'd291,  32'd0, 1, 1, 0, 16'd8, 16'd2, 0);
        idle(3);
        send(16'd291,  32'd0, 1, 0, 1, 16'd8, 16'd3, 0);
        idle(3);
        send(16'd2748, 32'd1, 1, 1, 0, 16'd9, 16'd3, 0);

        // Reset coincident with a valid code: the code is dropped
        @(negedge clk);
        reset          = 1'b1;
        bus.code_in    = 16'd2748;
        bus.code_valid = 1'b1;
        @(negedge clk);
        reset          = 1'b0;
        bus.code_valid = 1'b0;
        check_reset_state("reset_with_code");
        send(16'd291,  32'd0, 1, 0, 0, 16'd0, 16'd0, 0);
        send(16'd2748, 32'd1, 1, 1, 0, 16'd1, 16'd0, 0);

        // Drive error_count to FFFE with unknown codes, then probe saturation
        for (int i = 0; i < 65534; i++) begin
            send(16'h8000 | 16'(i & 32'h7FFF), 32'd1, 0, 0, 1, 16'd1, 16'(i + 1), 1);
        end
        send(16'h0000, 32'd1, 0, 0, 1, 16'd1, 16'hFFFF, 0);
        send(16'hFFFF, 32'd1, 0, 0, 1, 16'd1, 16'hFFFF, 0);
        send(16'h0124, 32'd1, 0, 0, 1, 16'd1, 16'hFFFF, 0);
        send(16'd291,  32'd0, 1, 0, 0, 16'd1, 16'hFFFF, 0);
        idle(3);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d responses outstanding, required 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_selection_decoder.md
Name: switch_selection_decoder

Overview:
- Receive end of the two-way switch-selection stream: consumes the 16-bit code word produced by the selection FSM and decodes it back to the 32-bit selector value.
- Checks that successive selections strictly alternate (0,1,0,1...), locks onto a valid stream, and counts matches and protocol errors.
- Sits beside the selection FSM as an in-design checker and decode path; its outputs feed bench monitors and status registers.

Parameters:
- CODE0, 16'd291 (16'h0123), code word that decodes to selector 0
- CODE1, 16'd2748 (16'h0ABC), code word that decodes to selector 1
- LOCK_COUNT, 2, consecutive correctly alternating codes required to assert locked (legal range 1..255)

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-high; clears all state on the posedge it is sampled high
- code_in  input  16  code word from the selection FSM
- code_valid  input  1  code_in is meaningful this cycle; one code consumed per cycle it is high
- sel_out  output  32  decoded selector (32'd0 or 32'd1); holds its last value when not updated
- sel_valid  output  1  one-cycle pulse: sel_out updated from a known code
- locked  output  1  stream is alternating correctly
- error_flag  output  1  one-cycle pulse on each protocol error
- match_count  output  16  saturating count of correctly alternating codes
- error_count  output  16  saturating count of protocol errors

Behaviour:
- Reset values: sel_out=0, sel_valid=0, locked=0, error_flag=0, match_count=0, error_count=0, FSM=INIT, run counter=0, expected=0.
- Latency: every output reflecting a code sampled at edge N is visible after edge N (registered, 1 cycle). When code_valid=0: no state change; sel_valid and error_flag are 0.
- Decode: CODE0->0, CODE1->1, any other value is unknown. A known code sets sel_out to the zero-extended value and pulses sel_valid. An unknown code leaves sel_out unchanged and sel_valid=0.
- FSM states:
  - INIT: waiting for the first known code.
    - Known code -> expected <= !decoded, run <= 1, go TRACK. If LOCK_COUNT==1, also set locked=1 and go LOCKED.
    - Unknown code -> error (see below), stay INIT.
  - TRACK: building up consecutive good codes.
    - decoded==expected -> match_count++, run++, expected toggles. When run reaches LOCK_COUNT: locked<=1, go LOCKED.
  - LOCKED: stream accepted.
    - decoded==expected -> match_count++, expected toggles.
  - Errors in TRACK or LOCKED:
    - Repeated selection (decoded != expected) -> error; locked<=0. The offending code becomes the new first code: expected <= !decoded, run <= 1, go TRACK.
    - Unknown code -> error; locked<=0, run<=0, go INIT.
- Error action: error_flag pulses for 1 cycle; error_count++.
- The first code after INIT is never counted as a match.
- Counters saturate at 16'hFFFF and do not wrap.
- Reset mid-stream: a code presented in the same cycle as reset is discarded and the module restarts in INIT.
- Codes are accepted back-to-back every cycle; no backpressure.

Test Plan:
- Reset, then code_valid every cycle with 291,2748,291,2748 -> sel_out 0,1,0,1; sel_valid each cycle; locked=1 after the 2nd code; match_count=3; error_count=0.
- Locked stream, then inject 2748 twice in a row -> error_flag pulses once, locked drops, error_count=1; next 291 re-locks (LOCK_COUNT=2); sel_out still tracks each code.
- Inject 16'h5555 while locked -> sel_out unchanged, sel_valid=0, error_flag=1, state INIT; following 291,2748 -> locked after the 2nd code.
- code_valid gaps (valid low for 3 cycles between codes) -> no state or counter change during gaps; alternation still checked across gaps.
- Assert reset in the same cycle as valid 2748 while locked -> all outputs return to reset values; that code is ignored; match_count=0.
- Force error_count to 16'hFFFE (via 0xFFFE unknown codes or a deposit), then 3 unknown codes -> error_count holds at 16'hFFFF.
